matrix_scan_driver: RTL and testbench

- Downstream stage of the flappy-bird game core.
- Consumes the GS×GS pixel frame the core produces and drives the physical LED matrix through row/column multiplexing.
- Frames are accepted over a valid/ready handshake into a pending buffer and promoted to the displayed buffer only at frame boundaries, so the display never shows a torn frame.
- Each row is shown for a fixed dwell time, followed by an all-off blanking gap that suppresses ghosting.

---
 rtl/matrix_scan_if.sv | 11 +
 rtl/matrix_scan_driver.sv | 140 ++++++++++++++
 tb/tb_matrix_scan_driver.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_if.sv
// Frame handshake between the game core (master) and the LED matrix scanner (slave).
interface matrix_scan_if #(
  parameter int unsigned GS = 8
);
  logic [GS*GS-1:0] frame_i;
  logic             frame_valid_i;
  logic             frame_ready_o;

  modport master (output frame_i, output frame_valid_i, input frame_ready_o);
  modport slave  (input frame_i, input frame_valid_i, output frame_ready_o);
endinterface

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed LED matrix driver: double-buffered frames, per-row dwell, blanking gap.
module matrix_scan_driver #(
  parameter int unsigned GS    = 8,
  parameter int unsigned DWELL = 1024,
  parameter int unsigned BLANK = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  matrix_scan_if.slave  fb,
  output logic [GS-1:0] row_o,
  output logic [GS-1:0] col_o,
  output logic          frame_start_o
);
  localparam int unsigned NPIX = GS * GS;
  localparam int unsigned RW   = (GS > 1) ? $clog2(GS) : 1;
  localparam int unsigned PMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [NPIX-1:0]   active_q, active_d;
  logic [NPIX-1:0]   pending_q, pending_d;
  logic              pending_full_q, pending_full_d;
  logic [GS-1:0]     row_out_q, row_out_d;
  logic [GS-1:0]     col_out_q, col_out_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_ready;
  logic              accept;
  logic              swap;

  assign frame_ready      = ~pending_full_q & rst_n;
  assign fb.frame_ready_o = frame_ready;
  assign accept           = fb.frame_valid_i & frame_ready;

  assign row_o         = row_out_q;
  assign col_o         = col_out_q;
  assign frame_start_o = frame_start_q;

  // Next-state, buffer management and registered-output preparation.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    phase_d        = phase_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    swap           = 1'b0;
    row_out_d      = '0;
    col_out_d      = '1;
    frame_start_d  = 1'b0;

    if (accept) begin
      pending_d      = fb.frame_i;
      pending_full_d = 1'b1;
    end

    if (!ena) begin
      state_d = S_IDLE;
      row_d   = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SHOW;
          row_d   = '0;
          phase_d = '0;
          swap    = pending_full_q;
        end
        S_SHOW: begin
          if (phase_q == PW'(DWELL - 1)) begin
            state_d = S_BLANK;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_BLANK: begin
          if (phase_q == PW'(BLANK - 1)) begin
            state_d = S_SHOW;
            phase_d = '0;
            // Wrapping past the last row is the only place a new frame may appear.
            if (row_q == RW'(GS - 1)) begin
              row_d = '0;
              swap  = pending_full_q;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          row_d   = '0;
          phase_d = '0;
        end
      endcase
    end

    if (swap) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end

    if (state_d == S_SHOW) begin
      row_out_d     = GS'(1) << row_d;
      col_out_d     = ~active_d[32'(row_d) * GS +: GS];
      frame_start_d = (row_d == '0) && (phase_d == '0);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      row_q          <= '0;
      phase_q        <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      row_out_q      <= '0;
      col_out_q      <= '1;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      phase_q        <= phase_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      row_out_q      <= row_out_d;
      col_out_q      <= col_out_d;
      frame_start_q  <= frame_start_d;
    end
  end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench for matrix_scan_driver: frames pushed on acceptance, popped per displayed frame.
module tb_matrix_scan_driver;
  localparam int unsigned GS    = 8;
  localparam int unsigned DWELL = 4;
  localparam int unsigned BLANK = 2;
  localparam logic [63:0] DIAG  = 64'h8040_2010_0804_0201;
  localparam logic [63:0] FR_A  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FR_B  = 64'hF0F0_0F0F_AA55_33CC;
  localparam logic [63:0] FR_C  = 64'hDEAD_BEEF_CAFE_1234;
  localparam logic [63:0] ZERO  = 64'h0;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] row_o;
  logic [7:0] col_o;
  logic       frame_start_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  matrix_scan_if #(.GS(GS)) fb ();

  matrix_scan_driver #(.GS(GS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .fb           (fb),
    .row_o        (row_o),
    .col_o        (col_o),
    .frame_start_o(frame_start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Present a frame until accepted (bounded); accepted frames enter the scoreboard.
  task automatic offer(input logic [63:0] f, input int limit,
                       output int waited, output logic accepted, output logic at_start);
    fb.frame_i       = f;
    fb.frame_valid_i = 1'b1;
    waited           = 0;
    while (fb.frame_ready_o !== 1'b1 && waited < limit) begin
      tick();
      waited++;
    end
    at_start = frame_start_o;
    accepted = (fb.frame_ready_o === 1'b1);
    if (accepted) begin
      tick();
      exp_q.push_back(f);
    end
    fb.frame_valid_i = 1'b0;
    fb.frame_i       = ~f;
  endtask

  // Walk one full frame from its first SHOW cycle; returns the image seen and a count of timing anomalies.
  task automatic capture_frame(output logic [63:0] img, output int terr);
    img  = '0;
    terr = 0;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < int'(DWELL); p++) begin
        if (row_o !== 8'(1 << r)) terr++;
        if (frame_start_o !== ((r == 0 && p == 0) ? 1'b1 : 1'b0)) terr++;
        if (p == 0) img[r*8 +: 8] = ~col_o;
        else if (~col_o !== img[r*8 +: 8]) terr++;
        tick();
      end
      for (int p = 0; p < int'(BLANK); p++) begin
        if (row_o !== 8'h00 || col_o !== 8'hFF || frame_start_o !== 1'b0) terr++;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1;
    fb.frame_valid_i = 1'b1; fb.frame_i = FR_A;
    repeat (3) tick();
    n_tests++; if (row_o !== 8'h00) begin n_fail++; $display("FAIL reset_row: got %h want 00", row_o); end
    n_tests++; if (col_o !== 8'hFF) begin n_fail++; $display("FAIL reset_col: got %h want ff", col_o); end
    n_tests++; if (frame_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start_o); end
    n_tests++; if (fb.frame_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", fb.frame_ready_o); end
    rst_n = 1'b1; ena = 1'b0; fb.frame_valid_i = 1'b0;
    #1;
    n_tests++; if (fb.frame_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", fb.frame_ready_o); end
  endtask

  task automatic test_diagonal();
    int w; logic acc, st; logic [63:0] img, want; int terr;
    offer(DIAG, 4, w, acc, st);
    n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL diag_accept: got %b want 1", acc); end
    ena = 1'b1;
    tick();
    n_tests++; if (frame_start_o !== 1'b1 || row_o !== 8'h01 || col_o !== 8'hFE) begin
      n_fail++; $display("FAIL diag_first: got fs=%b row=%h col=%h want 1/01/fe", frame_start_o, row_o, col_o);
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) exp_q.push_back(DIAG);
      n_tests++; if (frame_start_o !== 1'b1) begin n_fail++; $display("FAIL diag_period%0d: got fs=%b want 1", f, frame_start_o); end
      capture_frame(img, terr);
      want = pop_exp();
      n_tests++; if (img !== want) begin n_fail++; $display("FAIL diag_img%0d: got %h want %h", f, img, want); end
      n_tests++; if (terr !== 0) begin n_fail++; $display("FAIL diag_timing%0d: got %0d anomalies want 0", f, terr); end
    end
  endtask

  task automatic test_back_to_back();
    int wa, wb, wc; logic aa, ab, ac, sa, sb, sc;
    exp_q.push_back(DIAG);
    fork
      begin
        offer(FR_A, 4, wa, aa, sa);
        offer(FR_B, 200, wb, ab, sb);
        offer(FR_C, 200, wc, ac, sc);
        n_tests++; if (aa !== 1'b1 || wa !== 0) begin n_fail++; $display("FAIL b2b_a: got acc=%b wait=%0d want 1/0", aa, wa); end
        n_tests++; if (ab !== 1'b1 || wb !== 47 || sb !== 1'b1) begin
          n_fail++; $display("FAIL b2b_b: got acc=%b wait=%0d fs=%b want 1/47/1", ab, wb, sb);
        end
        n_tests++; if (ac !== 1'b1 || wc !== 47 || sc !== 1'b1) begin
          n_fail++; $display("FAIL b2b_c: got acc=%b wait=%0d fs=%b want 1/47/1", ac, wc, sc);
        end
      end
      begin
        logic [63:0] img, want; int terr;
        for (int i = 0; i < 4; i++) begin
          capture_frame(img, terr);
          want = pop_exp();
          n_tests++; if (img !== want || terr !== 0) begin
            n_fail++; $display("FAIL b2b_frame%0d: got %h (%0d anomalies) want %h", i, img, terr, want);
          end
        end
      end
    join
  endtask

  task automatic test_tear();
    logic [63:0] img, want; int terr;
    exp_q.push_back(FR_C);
    fork
      begin
        int w; logic acc, st;
        offer(ZERO, 4, w, acc, st);
        n_tests++; if (acc !== 1'b1 || w !== 0) begin n_fail++; $display("FAIL tear_zero_accept: got acc=%b wait=%0d", acc, w); end
      end
      begin
        logic [63:0] i2, w2; int t2;
        capture_frame(i2, t2);
        w2 = pop_exp();
        n_tests++; if (i2 !== w2 || t2 !== 0) begin n_fail++; $display("FAIL tear_prev: got %h (%0d) want %h", i2, t2, w2); end
      end
    join
    fork
      begin
        int w; logic acc, st;
        repeat (30) tick();
        n_tests++; if (row_o !== 8'h20) begin n_fail++; $display("FAIL tear_row5: got %h want 20", row_o); end
        offer(ONES, 4, w, acc, st);
        n_tests++; if (acc !== 1'b1 || w !== 0) begin n_fail++; $display("FAIL tear_ones_accept: got acc=%b wait=%0d", acc, w); end
      end
      begin
        capture_frame(img, terr);
        want = pop_exp();
        n_tests++; if (img !== want || terr !== 0) begin n_fail++; $display("FAIL tear_zero_frame: got %h (%0d) want %h", img, terr, want); end
      end
    join
    capture_frame(img, terr);
    want = pop_exp();
    n_tests++; if (img !== want || terr !== 0) begin n_fail++; $display("FAIL tear_ones_frame: got %h (%0d) want %h", img, terr, want); end
  endtask

  task automatic test_ena_drop();
    logic [63:0] img, want; int terr;
    repeat (20) tick();
    n_tests++; if (row_o !== 8'h08 || col_o !== 8'h00) begin n_fail++; $display("FAIL ena_row3: got row=%h col=%h want 08/00", row_o, col_o); end
    ena = 1'b0;
    tick();
    n_tests++; if (row_o !== 8'h00 || col_o !== 8'hFF) begin n_fail++; $display("FAIL ena_dark: got row=%h col=%h want 00/ff", row_o, col_o); end
    repeat (3) tick();
    n_tests++; if (row_o !== 8'h00 || frame_start_o !== 1'b0) begin n_fail++; $display("FAIL ena_idle: got row=%h fs=%b want 00/0", row_o, frame_start_o); end
    ena = 1'b1;
    tick();
    n_tests++; if (frame_start_o !== 1'b1 || row_o !== 8'h01) begin n_fail++; $display("FAIL ena_restart: got fs=%b row=%h want 1/01", frame_start_o, row_o); end
    exp_q.push_back(ONES);
    capture_frame(img, terr);
    want = pop_exp();
    n_tests++; if (img !== want || terr !== 0) begin n_fail++; $display("FAIL ena_image: got %h (%0d) want %h", img, terr, want); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] img, want; int terr;
    repeat (24) tick();
    n_tests++; if (row_o !== 8'h10) begin n_fail++; $display("FAIL rstmid_row4: got %h want 10", row_o); end
    rst_n = 1'b0;
    tick();
    n_tests++; if (row_o !== 8'h00 || col_o !== 8'hFF || fb.frame_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_dark: got row=%h col=%h rdy=%b want 00/ff/0", row_o, col_o, fb.frame_ready_o);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    n_tests++; if (fb.frame_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", fb.frame_ready_o); end
    tick();
    n_tests++; if (frame_start_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart: got fs=%b want 1", frame_start_o); end
    exp_q.push_back(ZERO);
    capture_frame(img, terr);
    want = pop_exp();
    n_tests++; if (img !== want || terr !== 0) begin n_fail++; $display("FAIL rstmid_image: got %h (%0d) want %h", img, terr, want); end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0;
    fb.frame_valid_i = 1'b0; fb.frame_i = '0;
    test_reset();
    test_diagonal();
    test_back_to_back();
    test_tear();
    test_ena_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
